// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel/line counters, sync pulses, visible-area flag
// and frame counter, all registered so every output describes the same pixel.
module vga_sync_gen #(
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned FCNT_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  output logic [9:0]        hpos,
  output logic [9:0]        vpos,
  output logic              hsync,
  output logic              vsync,
  output logic              visible,
  output logic              line_start,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_VIS + H_FP;
  localparam int unsigned HS_END  = H_VIS + H_FP + H_SYNC;
  localparam int unsigned VS_BEG  = V_VIS + V_FP;
  localparam int unsigned VS_END  = V_VIS + V_FP + V_SYNC;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must fit in 10 bits");
  end

  logic [9:0]        hpos_q, hpos_d;
  logic [9:0]        vpos_q, vpos_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              visible_q, visible_d;
  logic              lstart_q, lstart_d;
  logic              fstart_q, fstart_d;

  // Flags are decoded from the next counter values so they land in the same
  // register stage as the counters themselves.
  always_comb begin
    hpos_d = hpos_q;
    vpos_d = vpos_q;
    fcnt_d = fcnt_q;
    if (hpos_q == H_LAST) begin
      hpos_d = '0;
      if (vpos_q == V_LAST) begin
        vpos_d = '0;
        fcnt_d = fcnt_q + FCNT_W'(1);
      end else begin
        vpos_d = vpos_q + 10'd1;
      end
    end else begin
      hpos_d = hpos_q + 10'd1;
    end

    hsync_d   = (32'(hpos_d) >= HS_BEG && 32'(hpos_d) < HS_END) ? SYNC_POL : ~SYNC_POL;
    vsync_d   = (32'(vpos_d) >= VS_BEG && 32'(vpos_d) < VS_END) ? SYNC_POL : ~SYNC_POL;
    visible_d = (32'(hpos_d) < H_VIS) && (32'(vpos_d) < V_VIS);
    lstart_d  = (hpos_d == '0);
    fstart_d  = (hpos_d == '0) && (vpos_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q    <= '0;
      vpos_q    <= '0;
      fcnt_q    <= '0;
      hsync_q   <= ~SYNC_POL;
      vsync_q   <= ~SYNC_POL;
      visible_q <= 1'b0;
      lstart_q  <= 1'b0;
      fstart_q  <= 1'b0;
    end else if (pix_en) begin
      hpos_q    <= hpos_d;
      vpos_q    <= vpos_d;
      fcnt_q    <= fcnt_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      visible_q <= visible_d;
      lstart_q  <= lstart_d;
      fstart_q  <= fstart_d;
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign frame_cnt   = fcnt_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign visible     = visible_q;
  assign line_start  = lstart_q;
  assign frame_start = fstart_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a default 640x480 instance for line-level
// timing and a shrunken active-high instance for frame-level behaviour.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_d, en_d, rst_s, en_s;
  logic [9:0] hpos_d, vpos_d, hpos_s, vpos_s;
  logic       hsync_d, vsync_d, vis_d, ls_d, fs_d;
  logic       hsync_s, vsync_s, vis_s, ls_s, fs_s;
  logic [9:0] fcnt_d;
  logic [2:0] fcnt_s;

  int n_total = 0;
  int n_bad   = 0;

  vga_sync_gen dut_d (
    .clk(clk), .rst_n(rst_d), .pix_en(en_d),
    .hpos(hpos_d), .vpos(vpos_d), .hsync(hsync_d), .vsync(vsync_d),
    .visible(vis_d), .line_start(ls_d), .frame_start(fs_d), .frame_cnt(fcnt_d)
  );

  // 16 pixels x 12 lines, hsync on 10..12, vsync on lines 8..9, active-high
  vga_sync_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1), .FCNT_W(3)
  ) dut_s (
    .clk(clk), .rst_n(rst_s), .pix_en(en_s),
    .hpos(hpos_s), .vpos(vpos_s), .hsync(hsync_s), .vsync(vsync_s),
    .visible(vis_s), .line_start(ls_s), .frame_start(fs_s), .frame_cnt(fcnt_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected small-instance outputs after kk enabled edges from reset (kk>=1)
  task automatic chk_s(input int kk);
    int h, v, f;
    h = kk % 16;
    v = (kk / 16) % 12;
    f = (kk / 192) % 8;
    check("s_hpos",  hpos_s,  h);
    check("s_vpos",  vpos_s,  v);
    check("s_fcnt",  fcnt_s,  f);
    check("s_hsync", hsync_s, (h >= 10 && h < 13) ? 1 : 0);
    check("s_vsync", vsync_s, (v >= 8 && v < 10) ? 1 : 0);
    check("s_vis",   vis_s,   (h < 8 && v < 6) ? 1 : 0);
    check("s_ls",    ls_s,    (h == 0) ? 1 : 0);
    check("s_fs",    fs_s,    (h == 0 && v == 0) ? 1 : 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int eh, kk, vs_cnt, first;
    rst_d = 1'b0; rst_s = 1'b0; en_d = 1'b0; en_s = 1'b0;
    tick(); tick();

    check("d_rst_hpos",  hpos_d,  0);
    check("d_rst_vpos",  vpos_d,  0);
    check("d_rst_hsync", hsync_d, 1);
    check("d_rst_vsync", vsync_d, 1);
    check("d_rst_vis",   vis_d,   0);
    check("d_rst_ls",    ls_d,    0);
    check("d_rst_fs",    fs_d,    0);
    check("d_rst_fcnt",  fcnt_d,  0);

    rst_d = 1'b1; rst_s = 1'b1;
    tick();
    check("d_idle_hpos", hpos_d, 0);

    // Line 0 of the default raster, then the wrap into line 1
    en_d = 1'b1;
    for (int k = 1; k <= 800; k++) begin
      tick();
      eh = k % 800;
      check("d_line_hpos",  hpos_d,  eh);
      check("d_line_vis",   vis_d,   (eh < 640) ? 1 : 0);
      check("d_line_hsync", hsync_d, (eh >= 656 && eh < 752) ? 0 : 1);
      check("d_line_ls",    ls_d,    (eh == 0) ? 1 : 0);
    end
    check("d_line_vpos", vpos_d, 1);

    repeat (700) tick();
    check("d_mid_hpos",  hpos_d,  700);
    check("d_mid_hsync", hsync_d, 0);

    // Asynchronous reset with no clock edge in between
    #2 rst_d = 1'b0;
    #1;
    check("d_async_hpos",  hpos_d,  0);
    check("d_async_vpos",  vpos_d,  0);
    check("d_async_hsync", hsync_d, 1);
    check("d_async_vsync", vsync_d, 1);
    check("d_async_vis",   vis_d,   0);
    check("d_async_fcnt",  fcnt_d,  0);
    tick();
    rst_d = 1'b1;

    repeat (4799) tick();
    check("d_pre_hpos",  hpos_d,  799);
    check("d_pre_vpos",  vpos_d,  5);
    check("d_pre_hsync", hsync_d, 1);
    tick();
    check("d_wrap_hpos", hpos_d, 0);
    check("d_wrap_vpos", vpos_d, 6);
    check("d_wrap_ls",   ls_d,   1);
    check("d_wrap_fs",   fs_d,   0);
    check("d_wrap_vis",  vis_d,  1);

    en_d = 1'b0;
    repeat (3) tick();
    check("d_hold_hpos", hpos_d, 0);
    check("d_hold_vpos", vpos_d, 6);
    check("d_hold_ls",   ls_d,   1);

    // Small instance: idle after reset release, inactive level is 0
    check("s_idle_hpos",  hpos_s,  0);
    check("s_idle_hsync", hsync_s, 0);
    check("s_idle_vsync", vsync_s, 0);

    // Nine full frames so the 3-bit frame counter wraps
    en_s = 1'b1;
    vs_cnt = 0;
    for (int k = 1; k <= 1728; k++) begin
      tick();
      chk_s(k);
      if (k > 192 && k <= 384 && vsync_s === 1'b1) vs_cnt++;
    end
    check("s_vsync_len", vs_cnt, 32);

    // pix_en toggled every clock
    kk = 1728;
    for (int i = 0; i < 32; i++) begin
      en_s = (i % 2 == 0);
      tick();
      if (i % 2 == 0) kk++;
      chk_s(kk);
    end
    en_s = 1'b1;

    // Move into the second vsync line, then reset
    repeat (133) tick();
    kk = kk + 133;
    chk_s(kk);
    check("s_vs_pre_vpos",  vpos_s,  9);
    check("s_vs_pre_vsync", vsync_s, 1);
    #2 rst_s = 1'b0;
    #1;
    check("s_rst_vsync", vsync_s, 0);
    check("s_rst_hpos",  hpos_s,  0);
    check("s_rst_vpos",  vpos_s,  0);
    check("s_rst_fcnt",  fcnt_s,  0);
    tick();
    check("s_rst_hold_vsync", vsync_s, 0);
    rst_s = 1'b1;

    first = 0;
    for (int n = 1; n <= 400 && first == 0; n++) begin
      tick();
      if (vsync_s === 1'b1) begin
        first = n;
        check("s_vs_first_fcnt", fcnt_s, 0);
        check("s_vs_first_vpos", vpos_s, 8);
        check("s_vs_first_hpos", hpos_s, 0);
      end
    end
    check("s_vs_first", first, 128);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
